dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's MEM-stage data requests.
- Accepts one load/store request at a time over a valid/ready handshake.
- Inserts a configurable number of wait states, then returns read data or a write acknowledge.
- Raises a stall toward the hazard logic so the pipeline holds while a request is outstanding. It replaces the zero-latency data store.

---
 rtl/mem_if_pkg.sv | 43 ++++
 rtl/dmem_word_array.sv | 37 +++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, word
// geometry and the address legality check used at request acceptance.
package mem_if_pkg;

    // Responder FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Bytes per stored word
    localparam int WORD_BYTES = 4;

    // Ceiling log2, usable in constant expressions; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // An address is illegal when it is not word aligned or when any bit
    // above the word index is set (points past the end of storage).
    function automatic logic addr_error(input logic [31:0] addr, input int idx_bits);
        logic err;
        int   off_bits;
        off_bits = clog2(WORD_BYTES);
        err      = 1'b0;
        for (int b = 0; b < 32; b++) begin
            if (b < off_bits && addr[b]) begin
                err = 1'b1;
            end
            if (b >= idx_bits + off_bits && addr[b]) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Single-port word storage: synchronous write, registered read. Contents are
// never cleared by reset, so there is deliberately no reset input.
module dmem_word_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Read register keeps its value unless an enabled load occurs
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[idx];
        end
    end

    // Store commits and read capture share the one enabled port cycle
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[idx] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data responder: accepts one load/store at a time, waits LATENCY
// cycles, then strobes a single-cycle response and stalls the pipeline while
// the request is outstanding.
import mem_if_pkg::*;

module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int IDX_W = clog2(DEPTH_WORDS);
    localparam int OFF_W = clog2(WORD_BYTES);
    localparam int CNT_W = (LATENCY > 1) ? clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             load_ok_q, load_ok_d;
    logic             resp_err_q, resp_err_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             arr_en;
    logic [31:0]      arr_rdata;
    logic [31:0]      resp_rdata_now;

    // In RESP the load data comes straight from the array's read register;
    // otherwise the last response is held.
    always_comb begin
        resp_rdata_now = resp_rdata_q;
        if (state_q == ST_RESP) begin
            resp_rdata_now = load_ok_q ? arr_rdata : 32'h0;
        end
    end

    // Next-state logic. Every request, LATENCY==1 included, passes through
    // WAIT for LATENCY cycles so the response always lands after edge
    // N+LATENCY. The array access fires on the edge entering RESP and is
    // suppressed by reset so an aborted store never commits.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        load_ok_d    = load_ok_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        arr_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_addr[IDX_W+OFF_W-1:OFF_W];
                    wdata_d = req_wdata;
                    err_d   = addr_error(req_addr, IDX_W);
                    cnt_d   = CNT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_RESP;
                    arr_en     = ~err_q & ~rst;
                    resp_err_d = err_q;
                    load_ok_d  = ~err_q & ~write_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                resp_rdata_d = resp_rdata_now;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; storage is untouched by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'h0;
            err_q        <= 1'b0;
            load_ok_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            load_ok_q    <= load_ok_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    dmem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (clk),
        .en   (arr_en),
        .we   (write_q),
        .idx  (idx_q),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = resp_rdata_now;
    assign resp_err   = resp_err_q;
    assign stall      = req_valid & ~resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 instance driven by a
// vector table, hand sequences and randomized traffic against a simple
// word-array model, plus a LATENCY=1 instance for the short-latency timing.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic clk;
    logic rst;

    logic        a_req_valid, a_req_write, a_req_ready, a_resp_valid, a_resp_err, a_stall;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        b_req_valid, b_req_write, b_req_ready, b_resp_valid, b_resp_err, b_stall;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

    logic        use_b;
    logic        m_ready, m_valid, m_err, m_stall;
    logic [31:0] m_rdata;

    int          compared;
    int          mismatched;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_rdata [2];
    logic        last_err [2];

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .req_ready(a_req_ready), .resp_valid(a_resp_valid),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .stall(a_stall)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .req_ready(b_req_ready), .resp_valid(b_resp_valid),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .stall(b_stall)
    );

    assign m_ready = use_b ? b_req_ready  : a_req_ready;
    assign m_valid = use_b ? b_resp_valid : a_resp_valid;
    assign m_err   = use_b ? b_resp_err   : a_resp_err;
    assign m_stall = use_b ? b_stall      : a_stall;
    assign m_rdata = use_b ? b_resp_rdata : a_resp_rdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic got, input logic exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic driveReq(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (use_b) begin
            b_req_valid = v; b_req_write = w; b_req_addr = a; b_req_wdata = d;
        end else begin
            a_req_valid = v; a_req_write = w; a_req_addr = a; a_req_wdata = d;
        end
    endtask

    // Higher-level reference: legality from plain arithmetic on the address
    function automatic logic modelErr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] modelRead(input logic w, input logic [31:0] a);
        if (w || modelErr(a)) return 32'h0;
        return model_mem[a / 4];
    endfunction

    task automatic modelCommit(input logic w, input logic [31:0] a, input logic [31:0] d);
        if (w && !modelErr(a)) model_mem[a / 4] = d;
    endtask

    // One complete transaction on the selected DUT with full timing checks.
    // With scramble set, the request fields are trashed after acceptance.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] exp_rdata, input logic exp_err, input bit scramble);
        int lat;
        int cycles;
        bit seen;
        int sel;
        sel = use_b ? 1 : 0;
        lat = use_b ? 1 : LAT;
        @(negedge clk);
        checkBit("ready_idle", m_ready, 1'b1);
        checkBit("valid_idle", m_valid, 1'b0);
        checkOutput("rdata_hold", m_rdata, last_rdata[sel]);
        checkBit("err_hold", m_err, last_err[sel]);
        driveReq(1'b1, w, a, d);
        @(posedge clk);
        cycles = 0;
        seen   = 0;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (m_valid) begin
                seen = 1;
            end else begin
                checkBit("stall_wait", m_stall, 1'b1);
                checkBit("ready_wait", m_ready, 1'b0);
                if (scramble) driveReq(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
        end
        checkOutput("resp_latency", 32'(cycles), 32'(lat + 1));
        checkOutput("resp_rdata", m_rdata, exp_rdata);
        checkBit("resp_err", m_err, exp_err);
        checkBit("stall_resp", m_stall, 1'b0);
        checkBit("ready_resp", m_ready, 1'b0);
        driveReq(1'b0, 1'b0, 32'h0, 32'h0);
        last_rdata[sel] = exp_rdata;
        last_err[sel]   = exp_err;
        @(posedge clk);
    endtask

    // Abort a store with reset after waitCycles WAIT cycles on DUT A
    task automatic resetDuringWait(input int waitCycles, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        driveReq(1'b1, 1'b1, a, d);
        @(posedge clk);
        for (int i = 0; i < waitCycles; i++) begin
            @(negedge clk);
            checkBit("rst_wait_valid", a_resp_valid, 1'b0);
            checkBit("rst_wait_ready", a_req_ready, 1'b0);
        end
        rst = 1'b1;
        driveReq(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkBit("rst_ready", a_req_ready, 1'b1);
        checkBit("rst_valid", a_resp_valid, 1'b0);
        checkOutput("rst_rdata", a_resp_rdata, 32'h0);
        checkBit("rst_err", a_resp_err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkBit("rst_no_pulse", a_resp_valid, 1'b0);
        end
        last_rdata[0] = 32'h0;
        last_err[0]   = 1'b0;
    endtask

    initial begin
        int          resp_count;
        int          last_c;
        logic [31:0] want;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          r;

        compared   = 0;
        mismatched = 0;
        use_b      = 1'b0;
        rst        = 1'b1;
        a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        for (int i = 0; i < 2; i++) begin
            last_rdata[i] = 32'h0;
            last_err[i]   = 1'b0;
        end

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0014, 32'h0,         32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0012, 32'h0000_1234, 32'h0,         1'b1};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_00FC, 32'h55AA_55AA, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, 32'h0000_00FC, 32'h0,         32'h55AA_55AA, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0011, 32'h0,         32'h0,         1'b1};
        vecs[9]  = '{1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b1};
        vecs[10] = '{1'b1, 32'h0000_0100, 32'h0000_0077, 32'h0,         1'b1};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkBit("reset_ready", a_req_ready, 1'b1);
        checkBit("reset_valid", a_resp_valid, 1'b0);
        checkOutput("reset_rdata", a_resp_rdata, 32'h0);
        checkBit("reset_err", a_resp_err, 1'b0);
        checkBit("reset_stall", a_stall, 1'b0);

        $display("[TB] table vectors, LATENCY=%0d", LAT);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata,
                          vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
            modelCommit(vecs[i].write, vecs[i].addr, vecs[i].wdata);
        end

        $display("[TB] reset during WAIT");
        applyStimulus(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        resetDuringWait(1, 32'h20, 32'hCAFE_0000);
        applyStimulus(1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0);
        resetDuringWait(2, 32'h24, 32'hBAD0_BAD0);
        applyStimulus(1'b0, 32'h24, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // With req_valid held, an acceptance edge is followed by LATENCY
        // WAIT cycles, the RESP cycle and one IDLE cycle: pulses recur every
        // LATENCY+2 cycles, i.e. LATENCY+1 busy cycles between acceptances.
        $display("[TB] continuous requests");
        @(negedge clk);
        want = 32'h10;
        driveReq(1'b1, 1'b0, want, 32'h0);
        resp_count = 0;
        last_c     = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (a_resp_valid) begin
                resp_count++;
                checkOutput("b2b_rdata", a_resp_rdata, modelRead(1'b0, want));
                if (last_c >= 0) checkOutput("b2b_spacing", 32'(c - last_c), 32'(LAT + 2));
                last_c = c;
                last_rdata[0] = modelRead(1'b0, want);
                want = (want == 32'h10) ? 32'hFC : 32'h10;
                driveReq(1'b1, 1'b0, want, 32'h0);
            end
        end
        driveReq(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("b2b_count", 32'(resp_count), 32'd10);
        @(posedge clk);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (r < 7)       a = 32'($urandom_range(0, 15)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            else if (r == 8) a = ($urandom | 32'h100) & 32'hFFFF_FFFC;
            else             a = $urandom;
            applyStimulus(w, a, d, modelRead(w, a), modelErr(a), 1'b1);
            modelCommit(w, a, d);
        end

        $display("[TB] LATENCY=1 instance");
        use_b = 1'b1;
        applyStimulus(1'b1, 32'h8, 32'h0000_1111, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h8, 32'h0, 32'h0000_1111, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h3, 32'h0000_2222, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h4, 32'h0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h8, 32'h0, 32'h0000_1111, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
